// File: rtl/pcm_mm_scheduler.sv
// Single-outstanding access scheduler between the PCM request register and the
// on-chip memory Avalon-MM slave. Models short read latency and a long write settle.
//
// Handshake: schedule is a level held by the upstream register until it sees the
// one-cycle resolved pulse; the request is sampled and latched only in IDLE, so
// input changes while busy=1 are ignored. Exactly one access is outstanding.
module pcm_mm_scheduler #(
  parameter logic [8:0]  BASE_PAGE = 9'h000,
  parameter int          READ_LAT  = 2,
  parameter int          WRITE_LAT = 8,
  parameter logic [15:0] ERR_DATA  = 16'hDEAD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        schedule,
  input  logic [19:0] addr_reg,
  input  logic        cpu_write,
  input  logic [15:0] cpu_in,
  output logic        resolved,
  output logic [15:0] data_in,
  output logic        busy,
  output logic        addr_err,
  output logic [15:0] write_count,
  output logic [10:0] pcm_mem_mm_address,
  output logic        pcm_mem_mm_chipselect,
  output logic        pcm_mem_mm_clken,
  output logic        pcm_mem_mm_write,
  output logic [15:0] pcm_mem_mm_writedata,
  output logic [1:0]  pcm_mem_mm_byteenable,
  input  logic [15:0] pcm_mem_mm_readdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] RD_INIT = 8'(READ_LAT - 1);
  localparam logic [7:0] WR_INIT = 8'(WRITE_LAT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [15:0] din_q, din_d;

  logic        resolved_d, busy_d, addr_err_d;
  logic [15:0] data_in_d, write_count_d;
  logic [10:0] address_d;
  logic        cs_d, clken_d, mwrite_d;
  logic [15:0] wdata_d;
  logic [1:0]  be_d;

  // Every output is computed one cycle ahead here and registered below.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    wr_d          = wr_q;
    din_d         = din_q;
    resolved_d    = 1'b0;
    addr_err_d    = 1'b0;
    data_in_d     = data_in;
    write_count_d = write_count;
    address_d     = pcm_mem_mm_address;
    cs_d          = 1'b0;
    clken_d       = 1'b0;
    mwrite_d      = 1'b0;
    wdata_d       = 16'h0000;
    be_d          = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (schedule) begin
          wr_d  = cpu_write;
          din_d = cpu_in;
          if (addr_reg[19:11] != BASE_PAGE) begin
            state_d    = S_RESP;
            resolved_d = 1'b1;
            addr_err_d = 1'b1;
            data_in_d  = ERR_DATA;
          end else begin
            state_d   = S_ISSUE;
            cs_d      = 1'b1;
            clken_d   = 1'b1;
            be_d      = 2'b11;
            address_d = addr_reg[10:0];
            mwrite_d  = cpu_write;
            wdata_d   = cpu_write ? cpu_in : 16'h0000;
            if (cpu_write && (write_count != 16'hFFFF)) begin
              write_count_d = write_count + 16'd1;
            end
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = wr_q ? WR_INIT : RD_INIT;
        clken_d = 1'b1;
      end
      S_WAIT: begin
        if (cnt_q == 8'd0) begin
          state_d    = S_RESP;
          resolved_d = 1'b1;
          data_in_d  = wr_q ? din_q : pcm_mem_mm_readdata;
        end else begin
          cnt_d   = cnt_q - 8'd1;
          clken_d = 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q               <= S_IDLE;
      cnt_q                 <= 8'd0;
      wr_q                  <= 1'b0;
      din_q                 <= 16'h0000;
      resolved              <= 1'b0;
      data_in               <= 16'h0000;
      busy                  <= 1'b0;
      addr_err              <= 1'b0;
      write_count           <= 16'h0000;
      pcm_mem_mm_address    <= 11'h000;
      pcm_mem_mm_chipselect <= 1'b0;
      pcm_mem_mm_clken      <= 1'b0;
      pcm_mem_mm_write      <= 1'b0;
      pcm_mem_mm_writedata  <= 16'h0000;
      pcm_mem_mm_byteenable <= 2'b00;
    end else begin
      state_q               <= state_d;
      cnt_q                 <= cnt_d;
      wr_q                  <= wr_d;
      din_q                 <= din_d;
      resolved              <= resolved_d;
      data_in               <= data_in_d;
      busy                  <= busy_d;
      addr_err              <= addr_err_d;
      write_count           <= write_count_d;
      pcm_mem_mm_address    <= address_d;
      pcm_mem_mm_chipselect <= cs_d;
      pcm_mem_mm_clken      <= clken_d;
      pcm_mem_mm_write      <= mwrite_d;
      pcm_mem_mm_writedata  <= wdata_d;
      pcm_mem_mm_byteenable <= be_d;
    end
  end

endmodule
